// File: rtl/mold_msg_asm.sv
// mold_msg_asm: reassembles MoldUDP64 message beats into one wide message word.
// Optional saturating drop counter enabled by defining MOLD_MSG_ASM_DROP_CNT_EN.
module mold_msg_asm #(
   parameter int DATA_W = 64,
   parameter int KEEP_W = 8,
   parameter int LEN_W  = 16,
   parameter int MAX_B  = 64,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mold_msg_v_i,
   input  logic                 mold_msg_start_i,
   input  logic [LEN_W-1:0]     mold_msg_len_i,
   input  logic [KEEP_W-1:0]    mold_msg_mask_i,
   input  logic [DATA_W-1:0]    mold_msg_data_i,
   output logic                 msg_v_o,
   output logic [LEN_W-1:0]     msg_len_o,
   output logic [7:0]           msg_type_o,
   output logic [MAX_B*8-1:0]   msg_data_o,
   output logic                 ovf_o,
   output logic                 trunc_o,
   output logic [CNT_W-1:0]     drop_cnt_o
);

   localparam int KB = (KEEP_W > 1) ? $clog2(KEEP_W) : 1;
   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_B);

   typedef enum logic [1:0] {IDLE, ASM, DROP} state_t;

   state_t              state_q, state_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [MAX_B*8-1:0]  buf_q, buf_d;
   logic                msg_v_q, msg_v_d;
   logic                ovf_q, ovf_d;
   logic                trunc_q, trunc_d;
   logic [LEN_W-1:0]    msg_len_q, msg_len_d;
   logic [7:0]          type_q, type_d;
   logic [MAX_B*8-1:0]  out_q, out_d;

   logic                start;
   logic                wr_en;
   logic [LEN_W-1:0]    n;
   logic [LEN_W-1:0]    base;
   logic [LEN_W-1:0]    lenv;
   logic [LEN_W-1:0]    rem;
   logic [LEN_W-1:0]    wr;
   logic [LEN_W-1:0]    end_c;
   logic [LEN_W-1:0]    jj;
   logic [KB-1:0]       k;

   // Beat byte count from the valid mask
   always_comb begin
      n = '0;
      for (int i = 0; i < KEEP_W; i++) begin
         n = n + LEN_W'(mold_msg_mask_i[i]);
      end
   end

   // Offset arithmetic: a start beat restarts at offset 0 with the new length
   always_comb begin
      start = mold_msg_v_i & mold_msg_start_i;
      base  = start ? '0 : cnt_q;
      lenv  = start ? mold_msg_len_i : len_q;
      rem   = lenv - base;
      wr    = (n < rem) ? n : rem;
      end_c = base + wr;
   end

   // Next-state, buffer write and output capture
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      buf_d     = buf_q;
      msg_v_d   = 1'b0;
      ovf_d     = 1'b0;
      trunc_d   = 1'b0;
      msg_len_d = msg_len_q;
      type_d    = type_q;
      out_d     = out_q;
      wr_en     = 1'b0;
      jj        = '0;
      k         = '0;
      if (mold_msg_v_i) begin
         if (start) begin
            trunc_d = (state_q == ASM);
            len_d   = mold_msg_len_i;
            cnt_d   = '0;
            buf_d   = '0;
            if (mold_msg_len_i == '0) begin
               trunc_d = 1'b1;
               state_d = IDLE;
            end else if (mold_msg_len_i > MAX_L) begin
               ovf_d   = 1'b1;
               cnt_d   = end_c;
               state_d = (end_c == mold_msg_len_i) ? IDLE : DROP;
            end else begin
               wr_en   = 1'b1;
               cnt_d   = end_c;
               state_d = ASM;
            end
         end else begin
            unique case (state_q)
               IDLE: trunc_d = 1'b1;
               ASM: begin
                  wr_en = 1'b1;
                  cnt_d = end_c;
               end
               DROP: begin
                  cnt_d = end_c;
                  if (end_c == len_q) state_d = IDLE;
               end
               default: state_d = IDLE;
            endcase
         end
      end
      if (wr_en) begin
         for (int j = 0; j < MAX_B; j++) begin
            jj = LEN_W'(j);
            k  = KB'(jj - base);
            if (jj >= base && jj < end_c) begin
               buf_d[8*j +: 8] = mold_msg_data_i[{k, 3'b000} +: 8];
            end
         end
         if (end_c == lenv) begin
            state_d   = IDLE;
            msg_v_d   = 1'b1;
            msg_len_d = lenv;
            type_d    = buf_d[7:0];
            out_d     = buf_d;
         end
      end
   end

   // State, assembly buffer and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         len_q     <= '0;
         buf_q     <= '0;
         msg_v_q   <= 1'b0;
         ovf_q     <= 1'b0;
         trunc_q   <= 1'b0;
         msg_len_q <= '0;
         type_q    <= '0;
         out_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         buf_q     <= buf_d;
         msg_v_q   <= msg_v_d;
         ovf_q     <= ovf_d;
         trunc_q   <= trunc_d;
         msg_len_q <= msg_len_d;
         type_q    <= type_d;
         out_q     <= out_d;
      end
   end

   assign msg_v_o    = msg_v_q;
   assign msg_len_o  = msg_len_q;
   assign msg_type_o = type_q;
   assign msg_data_o = out_q;
   assign ovf_o      = ovf_q;
   assign trunc_o    = trunc_q;

`ifdef MOLD_MSG_ASM_DROP_CNT_EN
   logic [CNT_W-1:0] drop_q;

   // Saturating count of drop pulses, stepping with the pulse itself
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drop_q <= '0;
      end else if ((ovf_d | trunc_d) && drop_q != '1) begin
         drop_q <= drop_q + CNT_W'(1);
      end
   end

   assign drop_cnt_o = drop_q;
`else
   assign drop_cnt_o = '0;
`endif

endmodule
